// File: rtl/enigma_pkg.sv
// Shared constants and FSM encoding for the Enigma rotor datapath blocks.
package enigma_pkg;

  localparam int unsigned ALPHA = 26;  // letters per alphabet
  localparam int unsigned LW    = 5;   // letter index width

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } rotor_state_e;

endpackage

// File: rtl/mod26_addsub.sv
// Modular add/subtract over an ALPHA-letter alphabet; operands assumed in 0..ALPHA-1.
module mod26_addsub #(
  parameter int unsigned ALPHA = enigma_pkg::ALPHA,
  parameter int unsigned LW    = enigma_pkg::LW
) (
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  input  logic          add,
  output logic [LW-1:0] result
);

  localparam logic [LW:0] Mod = (LW+1)'(ALPHA);

  logic [LW:0] sum;
  logic [LW:0] sum_wrap;
  logic [LW:0] diff;
  logic [LW:0] diff_wrap;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign sum_wrap  = sum - Mod;
  assign diff      = {1'b0, a} - {1'b0, b};
  assign diff_wrap = diff + Mod;

  // One conditional correction brings either operation back into 0..ALPHA-1.
  always_comb begin
    result = '0;
    if (add) begin
      result = (sum >= Mod) ? sum_wrap[LW-1:0] : sum[LW-1:0];
    end else begin
      result = (a < b) ? diff_wrap[LW-1:0] : diff[LW-1:0];
    end
  end

endmodule

// File: rtl/rotor_reverse_path.sv
// Enigma rotor reverse (reflector-to-keyboard) path: loadable inverse wiring table
// feeding a two-stage valid/ready pipeline.
module rotor_reverse_path #(
  parameter int unsigned ALPHA = enigma_pkg::ALPHA,
  parameter int unsigned LW    = enigma_pkg::LW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load_en,
  input  logic [LW-1:0] load_idx,
  input  logic [LW-1:0] load_val,
  output logic          load_ack,
  output logic          table_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] in_letter,
  input  logic [LW-1:0] rotor_pos,
  input  logic [LW-1:0] ring_set,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_letter,
  output logic          err
);

  import enigma_pkg::*;

  localparam logic [LW-1:0] AlphaW = LW'(ALPHA);

  rotor_state_e     state_q, state_d;
  logic [ALPHA-1:0] mask_q, mask_d;
  logic [LW-1:0]    inv_q [ALPHA];

  logic             s1_valid_q, s1_valid_d;
  logic [LW-1:0]    s1_s_q;
  logic [LW-1:0]    s1_pr_q;   // position minus ring, reused to undo the offset
  logic             out_valid_q, out_valid_d;
  logic [LW-1:0]    out_letter_q;
  logic             err_q, err_d;

  logic             letter_ok;
  logic             load_ok;
  logic             load_we;
  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic [LW-1:0]    pr;
  logic [LW-1:0]    s_in;
  logic [LW-1:0]    inv_rd;
  logic [LW-1:0]    out_nxt;

  assign letter_ok   = (in_letter < AlphaW);
  assign load_ok     = (load_idx < AlphaW) && (load_val < AlphaW);
  assign load_we     = (state_q == StLoad) && load_en && load_ok;
  assign table_ready = &mask_q;
  assign s2_free     = !out_valid_q || out_ready;
  assign s1_adv      = s1_valid_q && s2_free;
  assign in_ready    = (state_q == StRun) && (!s1_valid_q || s1_adv);
  assign accept      = in_valid && in_ready;
  assign inv_rd      = inv_q[s1_s_q];

  assign load_ack    = load_we;
  assign out_valid   = out_valid_q;
  assign out_letter  = out_letter_q;
  assign err         = err_q;

  // (P - R) shared by the forward offset and its removal.
  mod26_addsub #(.ALPHA(ALPHA), .LW(LW)) u_pos_ring (
    .a      (rotor_pos),
    .b      (ring_set),
    .add    (1'b0),
    .result (pr)
  );

  // S = L + (P - R)
  mod26_addsub #(.ALPHA(ALPHA), .LW(LW)) u_in_off (
    .a      (in_letter),
    .b      (pr),
    .add    (1'b1),
    .result (s_in)
  );

  // out = inv[S] - (P - R)
  mod26_addsub #(.ALPHA(ALPHA), .LW(LW)) u_out_off (
    .a      (inv_rd),
    .b      (s1_pr_q),
    .add    (1'b0),
    .result (out_nxt)
  );

  // Mode FSM, written-mask maintenance and sticky range error.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    err_d   = err_q;
    unique case (state_q)
      StLoad:  if (table_ready) state_d = StRun;
      StRun:   if (load_en) state_d = StDrain;
      StDrain: begin
        if (!s1_valid_q && !out_valid_q) begin
          state_d = StLoad;
          mask_d  = '0;
        end
      end
      default: state_d = StLoad;
    endcase
    if (load_we) mask_d[load_val] = 1'b1;
    if ((state_q == StLoad) && load_en && !load_ok) err_d = 1'b1;
    if (accept && !letter_ok) err_d = 1'b1;
  end

  // Pipeline occupancy; out-of-range letters are consumed but never enter stage 1.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_adv) s1_valid_d = 1'b0;
    if (accept && letter_ok) s1_valid_d = 1'b1;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (s1_adv) out_valid_d = 1'b1;
  end

  // Control and pipeline state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StLoad;
      mask_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_s_q       <= '0;
      s1_pr_q      <= '0;
      out_valid_q  <= 1'b0;
      out_letter_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (accept && letter_ok) begin
        s1_s_q  <= s_in;
        s1_pr_q <= pr;
      end
      if (s1_adv) out_letter_q <= out_nxt;
    end
  end

  // Inverse wiring storage; validity is tracked by the mask, so no reset needed.
  always_ff @(posedge clk) begin
    if (load_we) inv_q[load_val] <= load_idx;
  end

endmodule

// File: tb/tb_rotor_reverse_path.sv
// Scoreboard bench for rotor_reverse_path: driver pushes model results, monitor pops on output.
module tb_rotor_reverse_path;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          load_en = 1'b0;
  logic [LW-1:0] load_idx = '0;
  logic [LW-1:0] load_val = '0;
  logic          load_ack;
  logic          table_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_letter = '0;
  logic [LW-1:0] rotor_pos = '0;
  logic [LW-1:0] ring_set = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW-1:0] out_letter;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int exp_q[$];
  int fwd[26];
  bit rp_done;

  always #5 clk = ~clk;

  rotor_reverse_path dut (
    .clk         (clk),
    .resetn      (resetn),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_val    (load_val),
    .load_ack    (load_ack),
    .table_ready (table_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_letter   (in_letter),
    .rotor_pos   (rotor_pos),
    .ring_set    (ring_set),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_letter  (out_letter),
    .err         (err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: offset into the rotor, find which input wires to that contact, remove offset.
  function automatic int ref_out(input int l, input int p, input int r);
    int s, i;
    s = (((l + p - r) % 26) + 26) % 26;
    i = -1;
    for (int k = 0; k < 26; k++) if (fwd[k] == s) i = k;
    return (((i - p + r) % 26) + 26) % 26;
  endfunction

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", int'(out_letter), -1);
      end else begin
        check("out_letter", int'(out_letter), exp_q.pop_front());
        n_out++;
      end
    end
  end

  task automatic load_entry(input int idx, input int val, input bit chk_drain, input int n_before);
    bit acked;
    acked = 1'b0;
    @(negedge clk);
    load_en  = 1'b1;
    load_idx = LW'(idx);
    load_val = LW'(val);
    for (int c = 0; c < 100 && !acked; c++) begin
      if (load_ack) acked = 1'b1;
      else @(negedge clk);
    end
    if (acked) begin
      if (chk_drain) begin
        check("drain_before_ack_queue", exp_q.size(), 0);
        check("drain_before_ack_count", n_out - n_before, 2);
      end
      @(posedge clk);
      #1 load_en = 1'b0;
    end else begin
      check("load_ack_timeout", int'(load_ack), 1);
      load_en = 1'b0;
    end
  endtask

  task automatic load_table(input bit chk_drain);
    int n_before;
    n_before = n_out;
    for (int i = 0; i < 26; i++) load_entry(i, fwd[i], chk_drain && (i == 0), n_before);
    @(negedge clk);
    check("table_ready_after_load", int'(table_ready), 1);
    @(negedge clk);
    check("in_ready_in_run", int'(in_ready), 1);
  endtask

  task automatic send(input int l, input int p, input int r);
    int c;
    @(negedge clk);
    in_valid  = 1'b1;
    in_letter = LW'(l);
    rotor_pos = LW'(p);
    ring_set  = LW'(r);
    c = 0;
    while (!in_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (l < 26) exp_q.push_back(ref_out(l, p, r));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic random_phase(input int n);
    rp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++)
          send($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
        rp_done = 1'b1;
      end
      begin
        while (!rp_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    string rotor_i;
    int    n_before;
    bit    saw_low;
    int    c;

    rotor_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_load_ack", int'(load_ack), 0);
    check("rst_table_ready", int'(table_ready), 0);
    check("rst_err", int'(err), 0);
    check("rst_out_letter", int'(out_letter), 0);
    resetn = 1'b1;

    // Identity wiring and two-cycle latency
    for (int k = 0; k < 26; k++) fwd[k] = k;
    load_table(1'b0);
    send(3, 0, 0);
    check("lat_not_yet", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_two_cycles", int'(out_valid), 1);
    check("lat_letter", int'(out_letter), 3);
    send(1, 25, 0);
    send(2, 0, 5);
    wait_drain();
    random_phase(30);
    check("err_still_clear", int'(err), 0);

    // Backpressure: out_ready low three cycles during a 4-letter burst
    out_ready = 1'b0;
    n_before  = n_out;
    saw_low   = 1'b0;
    fork
      begin
        send(7, 3, 1);
        send(12, 0, 9);
        send(25, 25, 25);
        send(0, 13, 2);
      end
      begin
        c = 0;
        @(negedge clk);
        while (!out_valid && c < 50) begin
          @(negedge clk);
          c++;
        end
        check("burst_first_valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_valid_held", int'(out_valid), 1);
          if (exp_q.size() != 0) check("stall_letter_held", int'(out_letter), exp_q[0]);
          if (!in_ready) saw_low = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("in_ready_dropped", int'(saw_low), 1);
    wait_drain();
    check("burst_count", n_out - n_before, 4);

    // Reload Rotor I while two letters are in flight
    out_ready = 1'b1;
    send(9, 4, 2);
    send(17, 1, 20);
    for (int k = 0; k < 26; k++) fwd[k] = int'(rotor_i[k]) - 65;
    load_table(1'b1);
    send(4, 0, 0);
    send(3, 1, 0);
    wait_drain();
    random_phase(30);

    // Out-of-range letter: err set, nothing produced
    send(30, 0, 0);
    @(posedge clk);
    #1;
    check("err_on_bad_letter", int'(err), 1);
    repeat (4) @(posedge clk);
    #1;
    check("bad_letter_no_result", int'(out_valid), 0);

    // Asynchronous reset mid-flight
    out_ready = 1'b0;
    send(5, 0, 0);
    send(6, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_err", int'(err), 0);
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_table_ready", int'(table_ready), 0);
    exp_q.delete();
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_still_load", int'(in_ready), 0);
    check("arst_no_output", int'(out_valid), 0);

    // 25 loads with one duplicate: table stays incomplete
    for (int i = 0; i < 24; i++) load_entry(i, fwd[i], 1'b0, 0);
    load_entry(24, fwd[0], 1'b0, 0);
    @(negedge clk);
    check("dup_table_not_ready", int'(table_ready), 0);
    in_valid = 1'b1;
    @(negedge clk);
    check("dup_in_ready_low", int'(in_ready), 0);
    in_valid = 1'b0;

    // Out-of-range load index: no write, err set
    load_en  = 1'b1;
    load_idx = LW'(27);
    load_val = LW'(3);
    #1;
    check("bad_load_no_ack", int'(load_ack), 0);
    @(posedge clk);
    #1 load_en = 1'b0;
    check("err_on_bad_load", int'(err), 1);
    check("bad_load_table_not_ready", int'(table_ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/rotor_reverse_path.md
ROTOR_REVERSE_PATH -- requirements
Module: rotor_reverse_path

Interface
REQ-001 SHALL take parameters ALPHA, default 26, letters per alphabet; LW, default 5, letter index width.
REQ-002 SHALL have ports, in order:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- load_en  in  1  request to write one forward-wiring entry.
- load_idx  in  LW  forward input letter.
- load_val  in  LW  forward output letter.
- load_ack  out  1  entry written this cycle.
- table_ready  out  1  all ALPHA inverse entries written.
- in_valid  in  1  letter offered.
- in_ready  out  1  letter accepted when in_valid and in_ready are both high.
- in_letter  in  LW  letter from reflector side.
- rotor_pos  in  LW  rotor position, sampled with the letter.
- ring_set  in  LW  ring setting, sampled with the letter.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_letter  out  LW  reverse-path result.
- err  out  1  sticky range-error flag.
REQ-003 SHALL use one clock, clk, with reset resetn asynchronous and active-low.

Function
REQ-004 SHALL compute, per accepted letter L with position P and ring R: S=(L+P-R) mod 26; I=inv[S]; out=(I-P+R) mod 26.
REQ-005 SHALL do mod-26 arithmetic on operands 0..25 as follows: addition with a 6-bit sum, minus 26 when the sum is 26 or more; subtraction adds 26 when the result is negative. No result SHALL be outside 0..25.
REQ-006 SHALL store inverse table inv[0..25] of LW bits, plus a 26-bit written-mask; a load sets inv[load_val]=load_idx and mask[load_val]=1.
REQ-007 SHALL define table_ready as 1 exactly when all mask bits are 1.
REQ-008 SHALL use FSM states LOAD, RUN, DRAIN:
- LOAD -> RUN when table_ready is 1.
- RUN -> DRAIN on load_en.
- DRAIN -> LOAD when both pipeline stages are empty; the mask clears on entry to LOAD.
REQ-009 SHALL assert load_ack and perform the write only in LOAD with load_en high, giving a one-cycle ack per entry; load_en in DRAIN is held off with no ack.
REQ-010 SHALL overwrite on duplicate load_val; the mask is unchanged and a missing entry keeps table_ready at 0.
REQ-011 SHALL ignore load_idx or load_val of 26 or more with no write, and set err.
REQ-012 SHALL hold in_ready at 0 in LOAD and DRAIN; in RUN, in_ready=!s1_valid || (s1 advancing).
REQ-013 SHALL register S, P and R in stage 1, and the output in stage 2: latency 2 cycles from accept to out_valid, throughput 1 letter per cycle while out_ready=1.
REQ-014 SHALL hold out_letter and out_valid stable while out_valid=1 and out_ready=0; upstream stalls and nothing is dropped or duplicated.
REQ-015 SHALL, for an accepted in_letter of 26 or more, set err, produce no result and drop the letter.
REQ-016 SHALL clear err only by reset.

Reset
REQ-017 SHALL, on resetn=0 (asynchronous, effective mid-transaction), set state=LOAD, mask=0, stage valids=0, out_valid=0, out_letter=0, in_ready=0, load_ack=0, table_ready=0, err=0; inv contents need not be reset.
REQ-018 SHALL discard in-flight letters on reset.

Structure
REQ-019 SHALL take ALPHA, LW and the FSM state encodings from shared package enigma_pkg.
REQ-020 SHALL use one sub-module, mod26_addsub (a, b, add -> result), instantiated three times for the mod-26 add/subtract.

Verification
REQ-021 Bench SHALL cover:
- Identity wiring loaded, P=0, R=0, in=3 -> out=3 two cycles later, table_ready=1.
- Rotor I wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ, P=0, R=0, in=4 -> out=0; P=1, R=0, in=3 -> out=25.
- Wrap case: identity, P=25, R=0, in=1 -> S=0, out=1; identity, P=0, R=5, in=2 -> out=2.
- out_ready low 3 cycles during 4-letter burst -> out_letter held, in_ready drops, all 4 results in order.
- Load 25 entries with one duplicate -> table_ready=0, in_ready=0; load_en during RUN with 2 in flight -> both results emitted before first load_ack.
- resetn pulsed with 2 letters in flight -> out_valid=0 immediately, state LOAD, err=0.
